// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage.
//   XLEN              datapath width (32 only)
//   alu_control_e     ALUControlE encodings
//   mul_div_op_e      MulDivOpE encodings (RV32M)
//   FWD_*             forwarding select encodings
//   mdu_state_t       multiply/divide FSM state, with MDU_* constants
package exec_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_control_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } mul_div_op_e;

  // Forwarding selects; 2'b11 is treated like FWD_RF.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t MDU_IDLE = 2'd0;
  localparam mdu_state_t MDU_BUSY = 2'd1;
  localparam mdu_state_t MDU_DONE = 2'd2;

endpackage

// File: rtl/execute_stage_mul_div_unit.sv
// Iterative RV32M multiply/divide unit (one radix-2 step per cycle).
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   start       accept an op in IDLE (already qualified with !flush)
//   flush       abandon any op, return to IDLE
//   op          mul_div_op_e encoding
//   a, b        forwarded operands, latched on accept
//   result      signed/selected result, valid while state == MDU_DONE
//   state       FSM state (IDLE/BUSY/DONE), exported for stall logic and debug
//
// Handshake: the requester holds start high with stable op; the unit latches
// a/b/op on the first start cycle in IDLE, and the requester must keep the
// instruction in place until state reads MDU_DONE, which is the single cycle
// the result is valid. The unit returns to IDLE on the following edge.
module mul_div_unit
  import exec_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output mdu_state_t      state
);

  logic [4:0]      count_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] opnd_q;      // multiplicand or divisor magnitude
  logic [63:0]     acc_q;       // {hi: partial product / remainder, lo: multiplier / quotient}
  logic            neg_res_q;   // negate product or quotient at the end
  logic            neg_rem_q;   // negate remainder at the end

  // Operand analysis for the accept cycle.
  logic            is_div, a_sgn, b_sgn, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    is_div   = op[2];
    a_sgn    = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    b_sgn    = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    neg_a    = a_sgn & a[XLEN-1];
    neg_b    = b_sgn & b[XLEN-1];
    mag_a    = neg_a ? (~a + 32'd1) : a;
    mag_b    = neg_b ? (~b + 32'd1) : b;
    div_zero = is_div && (b == 32'd0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
               (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  end

  // One iteration step of each algorithm.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;

  always_comb begin
    // Shift-add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole accumulator right (carry lands in bit 63).
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    // Restoring divide: bring the next dividend bit into the remainder and
    // keep the subtraction only if it did not go negative.
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_diff[32]) div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
    else              div_next = {div_diff[31:0],  acc_q[30:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MDU_IDLE;
      count_q   <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (flush) begin
      state <= MDU_IDLE;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            op_q    <= op;
            count_q <= '0;
            if (div_zero) begin
              // Architectural result: quotient all ones, remainder = dividend.
              acc_q     <= {a, 32'hFFFF_FFFF};
              neg_res_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state     <= MDU_DONE;
            end else if (div_ovf) begin
              acc_q     <= {32'd0, 32'h8000_0000};
              neg_res_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state     <= MDU_DONE;
            end else begin
              opnd_q    <= is_div ? mag_b : mag_a;
              acc_q     <= {32'd0, is_div ? mag_a : mag_b};
              neg_res_q <= neg_a ^ neg_b;
              neg_rem_q <= neg_a;
              state     <= MDU_BUSY;
            end
          end
        end
        MDU_BUSY: begin
          acc_q   <= op_q[2] ? div_next : mul_next;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) state <= MDU_DONE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

  // Sign correction and result selection, only meaningful in DONE.
  logic [63:0]     prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    case (op_q)
      MD_MUL:                       result = prod_fix[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[63:32];
      MD_DIV, MD_DIVU:              result = quo_fix;
      default:                      result = rem_fix;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage datapath: forwarding muxes, ALU, and (when EXECUTE_MDU_EN is
// defined) the iterative RV32M multiply/divide unit with its pipeline stall.
// Ports:
//   clk, reset                pipeline clock, synchronous active-high reset
//   ForwardA_E, ForwardB_E    operand selects (00 RF, 10 M, 01 W, 11 RF)
//   RD1E, RD2E                register-file operands
//   ALUResultM, ResultW       forwarding sources
//   ImmExtE, ALUSrcE          immediate and SrcB select
//   ALUControlE               ALU operation
//   MulDivE, MulDivOpE        M-extension op valid / opcode
//   FlushE                    kill the E-stage instruction
//   ExResultE                 ALU result, or MDU result in its DONE cycle
//   WriteDataE                forwarded B (store data)
//   ZeroE                     ExResultE == 0
//   StallMD                   MDU busy; stalls F/D/E upstream
// Configuration: define EXECUTE_MDU_EN to build the multiply/divide unit.
// Without it MulDivE/MulDivOpE are ignored and StallMD is tied low.
module execute_stage
  import exec_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic            ALUSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic            MulDivE,
  input  logic [2:0]      MulDivOpE,
  input  logic            FlushE,
  output logic [XLEN-1:0] ExResultE,
  output logic [XLEN-1:0] WriteDataE,
  output logic            ZeroE,
  output logic            StallMD
);

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
  logic [4:0]      shamt;

  always_comb begin
    case (ForwardA_E)
      FWD_MEM: src_a = ALUResultM;
      FWD_WB:  src_a = ResultW;
      default: src_a = RD1E;
    endcase
    case (ForwardB_E)
      FWD_MEM: fwd_b = ALUResultM;
      FWD_WB:  fwd_b = ResultW;
      default: fwd_b = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : fwd_b;
    shamt = src_b[4:0];
  end

  always_comb begin
    case (ALUControlE)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLT:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_result = {31'd0, src_a < src_b};
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
      default:  alu_result = '0;
    endcase
  end

  assign WriteDataE = fwd_b;
  assign ZeroE      = (ExResultE == '0);

`ifdef EXECUTE_MDU_EN
  mdu_state_t      mdu_state;
  logic [XLEN-1:0] mdu_result;

  // The MDU latches the forwarded B, not SrcB: an M op never uses the immediate.
  mul_div_unit u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (MulDivE & ~FlushE),
    .flush  (FlushE),
    .op     (MulDivOpE),
    .a      (src_a),
    .b      (fwd_b),
    .result (mdu_result),
    .state  (mdu_state)
  );

  // Stall drops in DONE so the result moves on to M in that same cycle.
  assign StallMD   = MulDivE & ~FlushE & ~reset & (mdu_state != MDU_DONE);
  assign ExResultE = (mdu_state == MDU_DONE) ? mdu_result : alu_result;
`else
  wire unused_mdu_inputs = &{1'b0, clk, reset, MulDivE, MulDivOpE, FlushE};

  assign StallMD   = 1'b0;
  assign ExResultE = alu_result;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: forwarding, ALU ops, and (when
// EXECUTE_MDU_EN is defined) MDU latency, results, operand hold and aborts.
module tb_execute_stage;
  import exec_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [31:0] RD1E, RD2E, ALUResultM, ResultW, ImmExtE;
  logic        ALUSrcE;
  logic [3:0]  ALUControlE;
  logic        MulDivE;
  logic [2:0]  MulDivOpE;
  logic        FlushE;
  logic [31:0] ExResultE, WriteDataE;
  logic        ZeroE, StallMD;

  execute_stage dut (
    .clk         (clk),
    .reset       (reset),
    .ForwardA_E  (ForwardA_E),
    .ForwardB_E  (ForwardB_E),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .ALUResultM  (ALUResultM),
    .ResultW     (ResultW),
    .ImmExtE     (ImmExtE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .MulDivE     (MulDivE),
    .MulDivOpE   (MulDivOpE),
    .FlushE      (FlushE),
    .ExResultE   (ExResultE),
    .WriteDataE  (WriteDataE),
    .ZeroE       (ZeroE),
    .StallMD     (StallMD)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_inputs();
    ForwardA_E = FWD_RF; ForwardB_E = FWD_RF;
    RD1E = 0; RD2E = 0; ALUResultM = 0; ResultW = 0; ImmExtE = 0;
    ALUSrcE = 1'b0; ALUControlE = ALU_ADD;
    MulDivE = 1'b0; MulDivOpE = 3'd0; FlushE = 1'b0;
  endtask

`ifdef EXECUTE_MDU_EN
  // Runs one M op to completion; counts stall cycles with a bounded loop.
  task automatic run_md(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_stalls,
                        input bit via_m);
    int n;
    ForwardA_E = via_m ? FWD_MEM : FWD_RF;
    if (via_m) ALUResultM = a; else RD1E = a;
    RD2E = b; ForwardB_E = FWD_RF;
    ALUSrcE = 1'b1; ImmExtE = 32'h1234_5678;   // must not reach the MDU
    ALUControlE = ALU_ADD;
    MulDivOpE = op; MulDivE = 1'b1; FlushE = 1'b0;
    #1;
    n = 0;
    while (StallMD && n < 40) begin
      n++;
      step();
      if (via_m && n == 1) ALUResultM = 32'hDEAD_BEEF;
      #1;
    end
    check_val({tag, " stall cycles"}, 32'(n), 32'(exp_stalls));
    check_val(tag, ExResultE, exp);
    MulDivE = 1'b0;
    step();
  endtask
`endif

  // ---------------- directed tables ----------------
  logic [1:0]  fa_sel [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic [31:0] fa_exp [4] = '{32'd6, 32'd8, 32'd10, 32'd6};

  logic [3:0]  alu_op  [11] = '{ALU_SRA, ALU_SLT, ALU_SLTU, ALU_SUB, ALU_AND, ALU_OR,
                                ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT, 4'd10};
  logic [31:0] alu_a   [11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                                32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'd1,
                                32'h8000_0000, 32'd1, 32'd5};
  logic [31:0] alu_b   [11] = '{32'd4, 32'd1, 32'd1, 32'd7, 32'hFF00_FF00, 32'h0F0F_0000,
                                32'hFF00_FF00, 32'h23, 32'd31, 32'hFFFF_FFFF, 32'd5};
  logic [31:0] alu_exp [11] = '{32'hF800_0000, 32'd1, 32'd0, 32'hFFFF_FFFE, 32'hF000_F000,
                                32'hFFFF_F0F0, 32'h00FF_FF00, 32'd8, 32'd1, 32'd0, 32'd0};

  initial begin
    set_idle_inputs();
    // Reset: StallMD forced low even with an M op presented; ALU follows inputs.
    reset = 1'b1;
    RD1E = 5; RD2E = 3; MulDivE = 1'b1; MulDivOpE = MD_DIV;
    step(); step();
    check_val("reset stall", {31'd0, StallMD}, 32'd0);
    check_val("reset alu", ExResultE, 32'd8);
    reset = 1'b0;
    set_idle_inputs();
    step();

    // Forwarding on A.
    RD1E = 5; ALUResultM = 7; ResultW = 9; ImmExtE = 1; ALUSrcE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ForwardA_E = fa_sel[i];
      #1;
      check_val($sformatf("fwd_a %0d", i), ExResultE, fa_exp[i]);
    end

    // Forwarding on B, store data and register SrcB.
    ForwardA_E = FWD_RF; ALUSrcE = 1'b0; RD2E = 20;
    ForwardB_E = 2'b10; #1;
    check_val("fwd_b mem wd", WriteDataE, 32'd7);
    check_val("fwd_b mem res", ExResultE, 32'd12);
    ForwardB_E = 2'b01; #1;
    check_val("fwd_b wb wd", WriteDataE, 32'd9);
    ForwardB_E = 2'b11; #1;
    check_val("fwd_b 11 wd", WriteDataE, 32'd20);
    check_val("fwd_b 11 res", ExResultE, 32'd25);

    // ALU operations via the immediate path.
    ForwardB_E = FWD_RF; ALUSrcE = 1'b1;
    for (int i = 0; i < 11; i++) begin
      ALUControlE = alu_op[i]; RD1E = alu_a[i]; ImmExtE = alu_b[i];
      #1;
      check_val($sformatf("alu %0d", i), ExResultE, alu_exp[i]);
      check_val($sformatf("zero %0d", i), {31'd0, ZeroE}, {31'd0, alu_exp[i] == 32'd0});
    end
    set_idle_inputs();
    step();

`ifdef EXECUTE_MDU_EN
    run_md("mulh",   MD_MULH,   32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33, 1'b0);
    run_md("mul",    MD_MUL,    32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 33, 1'b0);
    run_md("mulhu",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);
    run_md("div",    MD_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    run_md("rem",    MD_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    run_md("div neg divisor", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
    run_md("rem neg divisor", MD_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
    run_md("divu by 0", MD_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_md("remu by 0", MD_REMU, 32'd7, 32'd0, 32'd7, 1, 1'b0);
    run_md("div ovf",   MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_md("rem ovf",   MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    run_md("operand hold", MD_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);

    // Flush mid-BUSY: stall drops immediately, unit back in IDLE.
    set_idle_inputs();
    RD1E = 3; RD2E = 4; ImmExtE = 1; ALUSrcE = 1'b1;
    MulDivOpE = MD_MUL; MulDivE = 1'b1;
    for (int i = 0; i < 11; i++) step();
    FlushE = 1'b1; #1;
    check_val("flush stall", {31'd0, StallMD}, 32'd0);
    step();
    FlushE = 1'b0; MulDivE = 1'b0; #1;
    check_val("flush idle stall", {31'd0, StallMD}, 32'd0);
    check_val("flush idle alu", ExResultE, 32'd4);
    run_md("mul after flush", MD_MUL, 32'd3, 32'd4, 32'd12, 33, 1'b0);

    // Reset mid-BUSY aborts; a fresh op runs full length.
    set_idle_inputs();
    RD1E = 9; RD2E = 9; MulDivOpE = MD_MUL; MulDivE = 1'b1;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1; #1;
    check_val("reset busy stall", {31'd0, StallMD}, 32'd0);
    step();
    reset = 1'b0; MulDivE = 1'b0;
    step();
    run_md("mul after reset", MD_MUL, 32'd3, 32'd4, 32'd12, 33, 1'b0);
`else
    // Without the MDU, M ops are ignored entirely.
    RD1E = 7; RD2E = 2; MulDivOpE = MD_DIV; MulDivE = 1'b1; #1;
    check_val("no mdu stall", {31'd0, StallMD}, 32'd0);
    check_val("no mdu alu", ExResultE, 32'd9);
    step(); step();
    check_val("no mdu stall later", {31'd0, StallMD}, 32'd0);
    check_val("no mdu alu later", ExResultE, 32'd9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
